// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped cache.
// Exports cache_state_t and the default address-split widths.
package cache_pkg;

    localparam int DATA_W            = 32;
    localparam int DEF_LINE_ADDR_LEN = 3;
    localparam int DEF_SET_ADDR_LEN  = 3;
    localparam int DEF_TAG_ADDR_LEN  = 5;
    localparam int DEF_MEM_ADDR_LEN  = DEF_TAG_ADDR_LEN
                                     + DEF_SET_ADDR_LEN
                                     + DEF_LINE_ADDR_LEN;

    typedef enum logic [1:0] {
        IDLE,
        SWAP_OUT,
        SWAP_IN,
        SWAP_IN_OK
    } cache_state_t;

endpackage

// File: rtl/dm_cache_if.sv
// CPU data port and main-memory port of dm_cache.
// slave: cache side (drives rd_data/miss/mem_*), master: CPU + memory side.
interface dm_cache_if
    import cache_pkg::*;
#(
    parameter int ADDR_LEN = DEF_MEM_ADDR_LEN
);
    logic [ADDR_LEN-1:0] addr;
    logic                rd_req;
    logic                wr_req;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   rd_data;
    logic                miss;
    logic [ADDR_LEN-1:0] mem_addr;
    logic                mem_wr_req;
    logic [DATA_W-1:0]   mem_wr_data;
    logic [DATA_W-1:0]   mem_rd_data;

    modport slave (
        input  addr, rd_req, wr_req, wr_data, mem_rd_data,
        output rd_data, miss, mem_addr, mem_wr_req, mem_wr_data
    );

    modport master (
        output addr, rd_req, wr_req, wr_data, mem_rd_data,
        input  rd_data, miss, mem_addr, mem_wr_req, mem_wr_data
    );
endinterface

// File: rtl/cache_line_array.sv
// Data/tag/valid/dirty storage: combinational read, synchronous write.
// Ports: i_set/i_rd_off read select, i_we_word word write, i_mark_dirty, i_fill_done.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
    parameter int TAG_ADDR_LEN  = DEF_TAG_ADDR_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SET_ADDR_LEN-1:0]  i_set,
    input  logic [LINE_ADDR_LEN-1:0] i_rd_off,
    output logic [DATA_W-1:0]        o_rd_word,
    output logic                     o_valid,
    output logic                     o_dirty,
    output logic [TAG_ADDR_LEN-1:0]  o_tag,
    input  logic                     i_we_word,
    input  logic [LINE_ADDR_LEN-1:0] i_wr_off,
    input  logic [DATA_W-1:0]        i_wr_word,
    input  logic                     i_mark_dirty,
    input  logic                     i_fill_done,
    input  logic [TAG_ADDR_LEN-1:0]  i_fill_tag
);
    localparam int NSETS  = 1 << SET_ADDR_LEN;
    localparam int NWORDS = NSETS << LINE_ADDR_LEN;

    logic [DATA_W-1:0]       r_data [NWORDS];
    logic [TAG_ADDR_LEN-1:0] r_tag  [NSETS];
    logic [NSETS-1:0]        r_valid;
    logic [NSETS-1:0]        r_dirty;

    // Data and tags are not cleared; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (i_we_word) begin
            r_data[{i_set, i_wr_off}] <= i_wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_done) begin
            r_tag[i_set] <= i_fill_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_done) begin
            r_valid[i_set] <= 1'b1;
            r_dirty[i_set] <= 1'b0;
        end else if (i_mark_dirty) begin
            r_dirty[i_set] <= 1'b1;
        end
    end

    assign o_rd_word = r_data[{i_set, i_rd_off}];
    assign o_valid   = r_valid[i_set];
    assign o_dirty   = r_dirty[i_set];
    assign o_tag     = r_tag[i_set];

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped write-back write-allocate cache with miss FSM.
// Ports: clk, rst (async high), bus (CPU port + word-addressed memory port).
module dm_cache
    import cache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
    parameter int TAG_ADDR_LEN  = DEF_TAG_ADDR_LEN,
    parameter int MEM_ADDR_LEN  = TAG_ADDR_LEN + SET_ADDR_LEN
                                + LINE_ADDR_LEN
) (
    input  logic       clk,
    input  logic       rst,
    dm_cache_if.slave  bus
);
    localparam int CW = LINE_ADDR_LEN + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_N    = CW'(1 << LINE_ADDR_LEN);
    localparam logic [CW-1:0] CNT_LAST = CNT_N - CNT_ONE;

    cache_state_t r_state;
    cache_state_t w_next;

    logic [CW-1:0]            r_cnt;
    logic [TAG_ADDR_LEN-1:0]  r_victim_tag;

    logic [TAG_ADDR_LEN-1:0]  w_tag;
    logic [SET_ADDR_LEN-1:0]  w_set;
    logic [LINE_ADDR_LEN-1:0] w_off;
    logic [LINE_ADDR_LEN-1:0] w_k;
    logic [LINE_ADDR_LEN-1:0] w_cap;
    logic                     w_req;
    logic                     w_hit;

    logic [DATA_W-1:0]        w_rd_word;
    logic                     w_valid;
    logic                     w_dirty;
    logic [TAG_ADDR_LEN-1:0]  w_tag_q;

    logic [LINE_ADDR_LEN-1:0] w_rd_off;
    logic                     w_we_word;
    logic [LINE_ADDR_LEN-1:0] w_wr_off;
    logic [DATA_W-1:0]        w_wr_word;
    logic                     w_mark_dirty;
    logic                     w_fill_done;

    logic                     w_miss;
    logic [DATA_W-1:0]        w_rd_data;
    logic [MEM_ADDR_LEN-1:0]  w_mem_addr;
    logic                     w_mem_wr_req;
    logic [DATA_W-1:0]        w_mem_wr_data;

    assign w_tag = bus.addr[MEM_ADDR_LEN-1 -: TAG_ADDR_LEN];
    assign w_set = bus.addr[LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign w_off = bus.addr[LINE_ADDR_LEN-1:0];
    assign w_req = bus.rd_req | bus.wr_req;
    assign w_hit = w_valid & (w_tag_q == w_tag);
    assign w_k   = r_cnt[LINE_ADDR_LEN-1:0];
    // Memory read data lags the issued address by one cycle.
    assign w_cap = LINE_ADDR_LEN'(r_cnt - CNT_ONE);

    cache_line_array #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .SET_ADDR_LEN  (SET_ADDR_LEN),
        .TAG_ADDR_LEN  (TAG_ADDR_LEN)
    ) u_lines (
        .clk          (clk),
        .rst          (rst),
        .i_set        (w_set),
        .i_rd_off     (w_rd_off),
        .o_rd_word    (w_rd_word),
        .o_valid      (w_valid),
        .o_dirty      (w_dirty),
        .o_tag        (w_tag_q),
        .i_we_word    (w_we_word),
        .i_wr_off     (w_wr_off),
        .i_wr_word    (w_wr_word),
        .i_mark_dirty (w_mark_dirty),
        .i_fill_done  (w_fill_done),
        .i_fill_tag   (w_tag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_victim_tag <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_req && !w_hit) begin
                        r_victim_tag <= w_tag_q;
                    end
                end
                SWAP_OUT: begin
                    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
                end
                SWAP_IN: begin
                    r_cnt <= (r_cnt == CNT_N) ? '0 : r_cnt + CNT_ONE;
                end
                SWAP_IN_OK: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_next        = r_state;
        w_miss        = 1'b0;
        w_rd_data     = '0;
        w_mem_addr    = bus.addr;
        w_mem_wr_req  = 1'b0;
        w_mem_wr_data = '0;
        w_rd_off      = w_off;
        w_we_word     = 1'b0;
        w_wr_off      = w_off;
        w_wr_word     = bus.wr_data;
        w_mark_dirty  = 1'b0;
        w_fill_done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_rd_data = w_rd_word;
                end
                if (w_req && w_hit && bus.wr_req) begin
                    w_we_word    = 1'b1;
                    w_mark_dirty = 1'b1;
                end
                if (w_req && !w_hit) begin
                    w_miss = 1'b1;
                    w_next = (w_valid && w_dirty) ? SWAP_OUT : SWAP_IN;
                end
            end
            SWAP_OUT: begin
                w_miss        = w_req;
                w_rd_off      = w_k;
                w_mem_addr    = {r_victim_tag, w_set, w_k};
                w_mem_wr_req  = 1'b1;
                w_mem_wr_data = w_rd_word;
                if (r_cnt == CNT_LAST) begin
                    w_next = SWAP_IN;
                end
            end
            SWAP_IN: begin
                w_miss     = w_req;
                w_mem_addr = {w_tag, w_set, w_k};
                if (r_cnt != '0) begin
                    w_we_word = 1'b1;
                    w_wr_off  = w_cap;
                    w_wr_word = bus.mem_rd_data;
                end
                if (r_cnt == CNT_N) begin
                    w_next = SWAP_IN_OK;
                end
            end
            SWAP_IN_OK: begin
                w_miss      = w_req;
                w_fill_done = 1'b1;
                w_next      = IDLE;
            end
        endcase
    end

    assign bus.miss        = w_miss;
    assign bus.rd_data     = w_rd_data;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wr_req  = w_mem_wr_req;
    assign bus.mem_wr_data = w_mem_wr_data;

endmodule

// File: tb/tb_dm_cache.sv
// Directed + random bench for dm_cache against a flat-memory reference.
// Bench owns the main memory model attached to the cache's memory port.
module tb_dm_cache;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dm_cache_if #(.ADDR_LEN(11)) bus();

    dm_cache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Main memory: 1-cycle synchronous read, synchronous write.
    logic [31:0] mem [2048];
    int          wr_pulses = 0;

    always @(posedge clk) begin
        bus.mem_rd_data <= mem[bus.mem_addr];
        if (bus.mem_wr_req === 1'b1) begin
            mem[bus.mem_addr] = bus.mem_wr_data;
            wr_pulses = wr_pulses + 1;
        end
    end

    // Reference: what the CPU must observe, plus which line each set holds.
    logic [31:0] ref_mem [2048];
    bit          ref_valid [8];
    bit          ref_dirty [8];
    logic [4:0]  ref_tag   [8];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [10:0] a,
                         input logic [31:0] d, output int stall,
                         output logic [31:0] rdata);
        @(negedge clk);
        bus.addr    = a;
        bus.rd_req  = rd;
        bus.wr_req  = wr;
        bus.wr_data = d;
        #1;
        stall = 0;
        while (bus.miss === 1'b1 && stall < 200) begin
            stall++;
            @(negedge clk);
            #1;
        end
        rdata = bus.rd_data;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
    endtask

    // Applies one access and checks stall length, read data and write-back.
    task automatic do_op(input string tag, input bit rd, input bit wr,
                         input logic [10:0] a, input logic [31:0] d);
        int          set;
        logic [4:0]  tg;
        int          exp_stall;
        bit          evict;
        logic [4:0]  vtag;
        int          stall;
        logic [31:0] rdata;
        bit          wb_ok;
        set   = int'(a[5:3]);
        tg    = a[10:6];
        evict = 1'b0;
        vtag  = ref_tag[set];
        if (ref_valid[set] && ref_tag[set] == tg) begin
            exp_stall = 0;
        end else if (ref_valid[set] && ref_dirty[set]) begin
            exp_stall = 19;
            evict     = 1'b1;
        end else begin
            exp_stall = 11;
        end
        if (exp_stall != 0) begin
            ref_valid[set] = 1'b1;
            ref_dirty[set] = 1'b0;
            ref_tag[set]   = tg;
        end
        drive(rd, wr, a, d, stall, rdata);
        check({tag, ".stall"}, 32'(stall), 32'(exp_stall));
        if (wr) begin
            ref_mem[a]     = d;
            ref_dirty[set] = 1'b1;
        end else begin
            check({tag, ".rd"}, rdata, ref_mem[a]);
        end
        if (evict) begin
            wb_ok = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (mem[{vtag, a[5:3], 3'(k)}] !== ref_mem[{vtag, a[5:3], 3'(k)}])
                    wb_ok = 1'b0;
            end
            check({tag, ".wb"}, 32'(wb_ok), 32'd1);
        end
    endtask

    initial begin
        int          p0;
        int          stall;
        logic [31:0] rdata;
        logic [10:0] ra;
        int          op;

        bus.addr    = '0;
        bus.rd_req  = 1'b0;
        bus.wr_req  = 1'b0;
        bus.wr_data = '0;
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = 32'h1000 + i;
            ref_mem[i] = 32'h1000 + i;
        end
        for (int s = 0; s < 8; s++) begin
            ref_valid[s] = 1'b0;
            ref_dirty[s] = 1'b0;
            ref_tag[s]   = '0;
        end

        repeat (2) @(negedge clk);
        check("rst.rd_data", bus.rd_data, 32'h0);
        check("rst.miss", 32'(bus.miss), 32'h0);
        check("rst.mem_wr_req", 32'(bus.mem_wr_req), 32'h0);
        check("rst.mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst.mem_wr_data", bus.mem_wr_data, 32'h0);
        check("rst.state", 32'(dut.r_state), 32'(IDLE));
        rst = 1'b0;

        do_op("rd005", 1, 0, 11'h005, 0);
        do_op("rd005_hit", 1, 0, 11'h005, 0);
        do_op("rd000", 1, 0, 11'h000, 0);
        do_op("rd007", 1, 0, 11'h007, 0);

        do_op("wr003", 0, 1, 11'h003, 32'hDEAD);
        p0 = wr_pulses;
        do_op("rd103", 1, 0, 11'h103, 0);
        check("rd103.pulses", 32'(wr_pulses - p0), 32'd8);
        check("rd103.mem003", mem[3], 32'hDEAD);
        check("rd103.val", bus.rd_data, 32'h1103);

        do_op("rd103_hit", 1, 0, 11'h103, 0);
        p0 = wr_pulses;
        do_op("rd003_clean", 1, 0, 11'h003, 0);
        check("rd003.pulses", 32'(wr_pulses - p0), 32'd0);

        // Reset in the middle of a fill.
        @(negedge clk);
        bus.addr   = 11'h2A0;
        bus.rd_req = 1'b1;
        bus.wr_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.rd_req  = 1'b0;
        #1;
        check("midrst.state", 32'(dut.r_state), 32'(IDLE));
        check("midrst.miss", 32'(bus.miss), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 8; s++) begin
            ref_valid[s] = 1'b0;
            ref_dirty[s] = 1'b0;
        end
        do_op("rd2A0", 1, 0, 11'h2A0, 0);

        do_op("rdwr010", 1, 1, 11'h010, 32'h55);
        do_op("rd010", 1, 0, 11'h010, 0);

        for (int n = 0; n < 150; n++) begin
            ra = {5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7))};
            op = int'($urandom_range(0, 9));
            if (op < 6) begin
                do_op("rnd_rd", 1, 0, ra, 0);
            end else if (op < 9) begin
                do_op("rnd_wr", 0, 1, ra, $urandom);
            end else begin
                do_op("rnd_rdwr", 1, 1, ra, $urandom);
            end
        end
        idle();
        @(negedge clk);
        check("end.miss", 32'(bus.miss), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
